// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with a frame-aligned
// req/ack shadow load, so a published value never tears mid-frame.
module ssd_scan_ctrl #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic [3:0]  blank,
   input  logic        upd_req,
   output logic        upd_ack,
   output logic        frame_done,
   output logic [3:0]  annode,
   output logic [6:0]  cathod
);

   localparam logic [19:0] CNT_LAST = 20'(REFRESH_DIV - 1);

   logic [19:0] cnt;
   logic [1:0]  d;
   logic [15:0] shadow;
   logic        tick;
   logic        frame_end;
   logic [3:0]  nibble;
   logic [6:0]  seg;
   logic [3:0]  digit_sel;

   assign tick      = enable && (cnt == CNT_LAST);
   assign frame_end = tick && (d == 2'd3);
   assign nibble    = shadow[{d, 2'b00} +: 4];
   assign digit_sel = 4'b0001 << d;

   // Active-low gfedcba hex font
   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         d          <= '0;
         shadow     <= '0;
         upd_ack    <= 1'b0;
         frame_done <= 1'b0;
         annode     <= 4'b1111;
         cathod     <= 7'b1111111;
      end else begin
         if (enable) begin
            cnt <= tick ? '0 : cnt + 20'd1;
            if (tick)
               d <= d + 2'd1;
         end
         frame_done <= frame_end;
         upd_ack    <= frame_end && upd_req;
         // Load only at the frame boundary; new digits start with digit 0
         if (frame_end && upd_req)
            shadow <= value;
         // Segments are released whenever no anode is driven
         if (enable && !blank[d]) begin
            annode <= ~digit_sel;
            cathod <= seg;
         end else begin
            annode <= 4'b1111;
            cathod <= 7'b1111111;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with a 4-cycle digit slot (16-cycle frame).
module tb_ssd_scan_ctrl;

   logic        clock;
   logic        rst_n;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  blank;
   logic        upd_req;
   logic        upd_ack;
   logic        frame_done;
   logic [3:0]  annode;
   logic [6:0]  cathod;

   int total = 0;
   int bad   = 0;

   ssd_scan_ctrl #(.REFRESH_DIV(4)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .enable     (enable),
      .value      (value),
      .blank      (blank),
      .upd_req    (upd_req),
      .upd_ack    (upd_ack),
      .frame_done (frame_done),
      .annode     (annode),
      .cathod     (cathod)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, "_annode"}, 16'(annode), 16'h000F);
      chk({tag, "_cathod"}, 16'(cathod), 16'h007F);
      chk({tag, "_ack"}, 16'(upd_ack), 16'h0);
      chk({tag, "_frame_done"}, 16'(frame_done), 16'h0);
   endtask

   // Check n consecutive edges of a frame showing 'shown' with mask 'blk'.
   // Optionally raise a request after edge req_at, or freeze 10 cycles after edge freeze_at.
   task automatic run_frame(input logic [15:0] shown, input logic [3:0] blk,
                            input logic exp_ack, input int n, input int req_at,
                            input logic [15:0] req_val, input int freeze_at);
      logic [3:0] one;
      logic [3:0] exp_an;
      logic [6:0] exp_ca;
      int dig;
      one = 4'b0001;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         dig = i / 4;
         if (blk[dig]) begin
            exp_an = 4'b1111;
            exp_ca = 7'b1111111;
         end else begin
            exp_an = ~(one << dig);
            exp_ca = font(shown[dig*4 +: 4]);
         end
         chk($sformatf("annode[%0d]", i), 16'(annode), 16'(exp_an));
         chk($sformatf("cathod[%0d]", i), 16'(cathod), 16'(exp_ca));
         chk($sformatf("frame_done[%0d]", i), 16'(frame_done), 16'(i == 15));
         chk($sformatf("upd_ack[%0d]", i), 16'(upd_ack), 16'(exp_ack && i == 15));
         $display("edge %0d: annode=%b cathod=%b frame_done=%b upd_ack=%b",
                  i, annode, cathod, frame_done, upd_ack);
         if (i == req_at) begin
            value   = req_val;
            upd_req = 1'b1;
         end
         if (i == freeze_at) begin
            enable = 1'b0;
            repeat (10) begin
               @(negedge clock);
               chk_dark("freeze");
            end
            enable = 1'b1;
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b1;
      value   = 16'h0000;
      blank   = 4'b0000;
      upd_req = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      chk_dark("reset");
      rst_n = 1'b1;

      // Plain scan of shadow 0000
      run_frame(16'h0000, 4'b0000, 1'b0, 16, -1, 16'h0, -1);

      // Handshake raised mid-frame, acked at frame end together with frame_done
      run_frame(16'h0000, 4'b0000, 1'b1, 16, 5, 16'hA5C3, -1);
      upd_req = 1'b0;
      run_frame(16'hA5C3, 4'b0000, 1'b0, 16, -1, 16'h0, -1);

      // Blanking digits 1 and 3
      blank = 4'b1010;
      run_frame(16'hA5C3, 4'b1010, 1'b0, 16, -1, 16'h0, -1);
      blank = 4'b0000;

      // Enable freeze during digit 2, slot cycle 1
      run_frame(16'hA5C3, 4'b0000, 1'b0, 16, -1, 16'h0, 8);

      // Reset mid-handshake: request pending, reset before frame end
      value   = 16'h9999;
      upd_req = 1'b1;
      run_frame(16'hA5C3, 4'b0000, 1'b0, 5, -1, 16'h0, -1);
      rst_n = 1'b0;
      #1;
      chk_dark("midreset");
      @(negedge clock);
      rst_n = 1'b1;
      run_frame(16'h0000, 4'b0000, 1'b1, 16, -1, 16'h0, -1);
      upd_req = 1'b0;
      run_frame(16'h9999, 4'b0000, 1'b0, 16, -1, 16'h0, -1);

      // Held request across two frame ends with value changing after the first ack
      value   = 16'h1234;
      upd_req = 1'b1;
      run_frame(16'h9999, 4'b0000, 1'b1, 16, -1, 16'h0, -1);
      value = 16'h00FF;
      run_frame(16'h1234, 4'b0000, 1'b1, 16, -1, 16'h0, -1);
      upd_req = 1'b0;
      run_frame(16'h00FF, 4'b0000, 1'b0, 16, -1, 16'h0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
